// File: rtl/ripple_carry_adder.sv
// Registered unsigned ripple-carry adder built from a chain of one-bit full-adder cells.
// Sum carries the carry-out in its MSB; ovf flags two's-complement overflow of the same add.

module rca_full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);
   logic w_p;

   assign w_p    = i_a ^ i_b;
   assign o_s    = w_p ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & w_p);
endmodule

module ripple_carry_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             in_valid,
   output logic [WIDTH:0]   Sum,
   output logic             out_valid,
   output logic             ovf
);
   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH:0]   r_sum;
   logic             r_ovf;
   logic             r_vld;

   assign w_carry[0] = Cin;

   // Each cell's carry-out feeds the next cell's carry-in.
   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      rca_full_adder u_fa (
         .i_a    (A[i]),
         .i_b    (B[i]),
         .i_cin  (w_carry[i]),
         .o_s    (w_sum[i]),
         .o_cout (w_carry[i+1])
      );
   end

   // Result and ovf only load on a qualified input, so X operands while idle never reach them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sum <= '0;
         r_ovf <= 1'b0;
         r_vld <= 1'b0;
      end else begin
         r_vld <= in_valid;
         if (in_valid) begin
            r_sum <= {w_carry[WIDTH], w_sum};
            r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
         end
      end
   end

   assign Sum       = r_sum;
   assign out_valid = r_vld;
   assign ovf       = r_ovf;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Bench for ripple_carry_adder: three instances (WIDTH 1, 4, 8) share control inputs and
// are compared each cycle against an arithmetic reference model.

module tb_ripple_carry_adder;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] A8, B8;
   logic       Cin, in_valid;
   logic [1:0] Sum1;
   logic [4:0] Sum4;
   logic [8:0] Sum8;
   logic       ov1, ov4, ov8, vl1, vl4, vl8;

   int checks   = 0;
   int failures = 0;

   int exp_sum[3];
   bit exp_ovf[3];
   bit exp_vld;
   int widths[3] = '{1, 4, 8};

   always #5 clk = ~clk;

   ripple_carry_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .A(A8[0:0]), .B(B8[0:0]), .Cin(Cin), .in_valid(in_valid),
      .Sum(Sum1), .out_valid(vl1), .ovf(ov1));
   ripple_carry_adder #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .A(A8[3:0]), .B(B8[3:0]), .Cin(Cin), .in_valid(in_valid),
      .Sum(Sum4), .out_valid(vl4), .ovf(ov4));
   ripple_carry_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .A(A8), .B(B8), .Cin(Cin), .in_valid(in_valid),
      .Sum(Sum8), .out_valid(vl8), .ovf(ov8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact unsigned sum, and signed-range test for overflow.
   task automatic model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic v, input logic rn);
      for (int k = 0; k < 3; k++) begin
         int w, ua, ub, sa, sb, ss, lim;
         w   = widths[k];
         lim = 1 << (w - 1);
         if (!rn) begin
            exp_sum[k] = 0;
            exp_ovf[k] = 1'b0;
         end else if (v) begin
            ua = int'(a) & ((1 << w) - 1);
            ub = int'(b) & ((1 << w) - 1);
            exp_sum[k] = ua + ub + int'(cin);
            sa = (ua >= lim) ? ua - (1 << w) : ua;
            sb = (ub >= lim) ? ub - (1 << w) : ub;
            ss = sa + sb + int'(cin);
            exp_ovf[k] = (ss > lim - 1) || (ss < -lim);
         end
      end
      exp_vld = rn && v;
   endtask

   task automatic step(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic v, input logic rn, input string tag);
      A8 = a; B8 = b; Cin = cin; in_valid = v; rst_n = rn;
      @(posedge clk);
      #1;
      model(a, b, cin, v, rn);
      chk({tag, "_sum1"}, 32'(Sum1), 32'(exp_sum[0]));
      chk({tag, "_sum4"}, 32'(Sum4), 32'(exp_sum[1]));
      chk({tag, "_sum8"}, 32'(Sum8), 32'(exp_sum[2]));
      chk({tag, "_ovf1"}, 32'(ov1), 32'(exp_ovf[0]));
      chk({tag, "_ovf4"}, 32'(ov4), 32'(exp_ovf[1]));
      chk({tag, "_ovf8"}, 32'(ov8), 32'(exp_ovf[2]));
      chk({tag, "_vld1"}, 32'(vl1), 32'(exp_vld));
      chk({tag, "_vld4"}, 32'(vl4), 32'(exp_vld));
      chk({tag, "_vld8"}, 32'(vl8), 32'(exp_vld));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ra, rb;
      logic       rc, rv, rr;

      // Reset for two edges, then idle.
      step(8'd0, 8'd0, 1'b0, 1'b1, 1'b0, "rst0");
      step(8'd9, 8'd9, 1'b1, 1'b1, 1'b0, "rst1");
      chk("rst_sum_lit", 32'(Sum4), 32'd0);
      step(8'd0, 8'd0, 1'b0, 1'b0, 1'b1, "idle");
      chk("idle_vld_lit", 32'(vl4), 32'd0);

      // Directed table, literal expectations for WIDTH=4.
      step(8'd0, 8'd0, 1'b1, 1'b1, 1'b1, "t0");    chk("t0_lit", 32'(Sum4), 32'd1);
      step(8'd1, 8'd5, 1'b1, 1'b1, 1'b1, "t1");    chk("t1_lit", 32'(Sum4), 32'd7);
      step(8'd2, 8'd9, 1'b0, 1'b1, 1'b1, "t2");    chk("t2_lit", 32'(Sum4), 32'd11);
      step(8'd7, 8'd11, 1'b1, 1'b1, 1'b1, "t3");   chk("t3_lit", 32'(Sum4), 32'b10011);
      step(8'd10, 8'd3, 1'b0, 1'b1, 1'b1, "t4");   chk("t4_lit", 32'(Sum4), 32'd13);
      step(8'd15, 8'd15, 1'b0, 1'b1, 1'b1, "t5");  chk("t5_lit", 32'(Sum4), 32'b11110);
      step(8'd15, 8'd0, 1'b1, 1'b1, 1'b1, "rip0"); chk("rip0_lit", 32'(Sum4), 32'd16);
      step(8'd15, 8'd15, 1'b1, 1'b1, 1'b1, "rip1"); chk("rip1_lit", 32'(Sum4), 32'd31);
      step(8'd7, 8'd1, 1'b0, 1'b1, 1'b1, "ov0");
      chk("ov0_lit", 32'(ov4), 32'd1); chk("ov0_sum_lit", 32'(Sum4), 32'd8);
      step(8'd8, 8'd8, 1'b0, 1'b1, 1'b1, "ov1");
      chk("ov1_lit", 32'(ov4), 32'd1); chk("ov1_sum_lit", 32'(Sum4), 32'd16);
      step(8'd3, 8'd2, 1'b0, 1'b1, 1'b1, "ov2");   chk("ov2_lit", 32'(ov4), 32'd0);

      // Hold with idle operands, including X.
      step(8'd2, 8'd9, 1'b0, 1'b1, 1'b1, "h0");
      step(8'd15, 8'd15, 1'b1, 1'b0, 1'b1, "h1");  chk("h1_lit", 32'(Sum4), 32'd11);
      step(8'hxx, 8'hxx, 1'bx, 1'b0, 1'b1, "hx");  chk("hx_lit", 32'(Sum4), 32'd11);

      // Reset colliding with a valid input.
      step(8'd5, 8'd6, 1'b1, 1'b1, 1'b1, "m0");
      step(8'd12, 8'd13, 1'b1, 1'b1, 1'b0, "m1");
      chk("m1_sum_lit", 32'(Sum4), 32'd0); chk("m1_vld_lit", 32'(vl4), 32'd0);

      // Exhaustive WIDTH=4 sweep (low bits cover WIDTH=1), back-to-back valid.
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++)
               step(8'(a), 8'(b), 1'(c), 1'b1, 1'b1, "ex");

      // Random mix on all widths with sporadic idle cycles and resets.
      for (int n = 0; n < 400; n++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 19) != 0);
         step(ra, rb, rc, rv, rr, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
